nonce_uplink_arbiter: RTL
=========================

NONCE_UPLINK_ARBITER -- requirements
Module: nonce_uplink_arbiter

Interface
REQ-001 SHALL have parameter SLAVES, default 8, number of nonce-reporting slave ports (1..64).
REQ-002 SHALL have parameter ACK_TIMEOUT, default 4, max cycles in WAIT_ACK waiting for tx_busy high.
REQ-003 SHALL have port hash_clk  input  1  sole clock; all logic on posedge.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have port slave_nonces  input  SLAVES*32  nonce of slave i on bits [i*32+31:i*32].
REQ-006 SHALL have port new_nonces  input  SLAVES  one-cycle strobe per slave, nonce valid in same cycle.
REQ-007 SHALL have port tx_busy  input  1  serial transmitter busy.
REQ-008 SHALL have port tx_send  output  1  one-cycle start pulse to serial transmitter.
REQ-009 SHALL have port tx_word  output  32  word to transmit; stable from tx_send until return to IDLE.
REQ-010 SHALL have port pending  output  SLAVES  per-slave "nonce held, not yet sent" flags.

Function
REQ-011 SHALL hold one 32-bit register and one pending bit per slave; new_nonces[i]=1 loads hold[i] from slice i and sets pending[i] next cycle.
REQ-012 SHALL implement states IDLE, SEND, WAIT_ACK, WAIT_DONE, all registered.
REQ-013 In IDLE with tx_busy=0 and any pending bit set, SHALL grant the first set bit searching upward (wrapping) from rr_ptr, load tx_word with hold[grant], clear pending[grant], set rr_ptr=(grant+1) mod SLAVES, go to SEND.
REQ-014 SEND SHALL last exactly one cycle with tx_send=1, then go to WAIT_ACK; tx_send SHALL be 0 in every other state.
REQ-015 WAIT_ACK SHALL go to WAIT_DONE when tx_busy=1, or to IDLE after ACK_TIMEOUT cycles without tx_busy=1 (word considered lost, not retried).
REQ-016 WAIT_DONE SHALL go to IDLE on the first cycle tx_busy=0.
REQ-017 Latency: strobe in cycle t, uplink idle -> pending[i]=1 in t+1, tx_send=1 in t+2.
REQ-018 Strobe on slave i while pending[i]=1 SHALL overwrite hold[i] (newest wins), pending stays 1.
REQ-019 Strobe on slave i in the cycle it is granted: tx_word takes old hold[i], hold[i] takes new value, pending[i] ends 1.
REQ-020 Simultaneous strobes on several slaves SHALL all be captured in the same cycle.
REQ-021 Starvation bound: a pending slave SHALL be granted within SLAVES grants.
REQ-022 rr_ptr SHALL wrap from SLAVES-1 to 0; width $clog2(SLAVES) with minimum 1.

Reset
REQ-023 rst=1 SHALL set state IDLE, tx_send=0, tx_word=0, pending=0, rr_ptr=0, hold registers 0, overriding strobes in the same cycle.
REQ-024 Reset mid-transfer SHALL abandon the word; first post-reset grant SHALL still wait for tx_busy=0.

Configuration
REQ-025 With macro NONCE_OVERRUN_COUNT_EN defined, SHALL add output overrun_count (16 bits, reset 0) incrementing, saturating at 0xFFFF, once per cycle in which at least one REQ-018 overwrite occurs; without it, no port and no counter logic.

Verification
REQ-026 Single strobe slave 3 nonce 0xDEADBEEF, tx_busy=0 -> tx_send 2 cycles later, tx_word=0xDEADBEEF, pending[3] clears.
REQ-027 All 8 slaves strobe in one cycle (nonce=i), transmitter model busy 10 cycles per send -> words sent in order 0..7, one tx_send each.
REQ-028 Slave 5 strobes 0x1 then 0x2 while uplink busy -> only 0x2 sent; overrun_count=1 with NONCE_OVERRUN_COUNT_EN.
REQ-029 tx_busy held 0 after tx_send -> IDLE after 4 cycles, next pending slave granted.
REQ-030 rst asserted during WAIT_DONE with pending=0x0F -> pending=0, tx_send=0, no send until new strobes.
REQ-031 Slave 0 strobes every 3 cycles continuously, slave 7 strobes once -> slave 7 sent within 8 grants.

Source files
------------

// File: rtl/nonce_uplink_arbiter.sv
// Collects nonces from SLAVES ports and forwards them round-robin, one word at a time, to a serial uplink.
// Optional macro NONCE_OVERRUN_COUNT_EN adds a saturating count of cycles in which a held nonce was overwritten.
module nonce_uplink_arbiter #(
  parameter int SLAVES      = 8,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic                 hash_clk,
  input  logic                 rst,
  input  logic [SLAVES*32-1:0] slave_nonces,
  input  logic [SLAVES-1:0]    new_nonces,
  input  logic                 tx_busy,
  output logic                 tx_send,
  output logic [31:0]          tx_word,
  output logic [SLAVES-1:0]    pending
`ifdef NONCE_OVERRUN_COUNT_EN
  ,
  output logic [15:0]          overrun_count
`endif
);

  localparam int PTR_W = (SLAVES > 1) ? $clog2(SLAVES) : 1;
  localparam int TMO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK, WAIT_DONE} state_t;

  state_t            state, state_next;
  logic [31:0]       hold [SLAVES];
  logic [PTR_W-1:0]  rr_ptr;
  logic [TMO_W-1:0]  ack_cnt;
  logic              grant_valid;
  logic              grant_take;
  logic [PTR_W-1:0]  grant_idx;
  logic [SLAVES-1:0] grant_mask;

  // First pending slave at or above rr_ptr, wrapping past SLAVES-1.
  always_comb begin
    logic [PTR_W:0] sum;
    grant_valid = 1'b0;
    grant_idx   = '0;
    sum         = '0;
    for (int k = 0; k < SLAVES; k++) begin
      sum = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (sum >= (PTR_W+1)'(SLAVES)) sum = sum - (PTR_W+1)'(SLAVES);
      if (!grant_valid && pending[sum[PTR_W-1:0]]) begin
        grant_valid = 1'b1;
        grant_idx   = sum[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    state_next = state;
    grant_take = 1'b0;
    case (state)
      IDLE: begin
        if (!tx_busy && grant_valid) begin
          grant_take = 1'b1;
          state_next = SEND;
        end
      end
      SEND:     state_next = WAIT_ACK;
      WAIT_ACK: begin
        if (tx_busy) state_next = WAIT_DONE;
        else if (ack_cnt == TMO_W'(ACK_TIMEOUT-1)) state_next = IDLE;
      end
      WAIT_DONE: if (!tx_busy) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  assign grant_mask = grant_take ? (SLAVES'(1) << grant_idx) : '0;
  assign tx_send    = (state == SEND);

  always_ff @(posedge hash_clk) begin
    if (rst) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      ack_cnt <= '0;
      tx_word <= '0;
    end else begin
      state <= state_next;
      if (state != WAIT_ACK)  ack_cnt <= '0;
      else if (!tx_busy)      ack_cnt <= ack_cnt + 1'b1;
      if (grant_take) begin
        tx_word <= hold[grant_idx];
        rr_ptr  <= (grant_idx == PTR_W'(SLAVES-1)) ? '0 : grant_idx + 1'b1;
      end
    end
  end

  // A strobe in the grant cycle re-arms pending, so the newer nonce is sent later.
  always_ff @(posedge hash_clk) begin
    if (rst) begin
      pending <= '0;
      for (int i = 0; i < SLAVES; i++) hold[i] <= '0;
    end else begin
      pending <= (pending & ~grant_mask) | new_nonces;
      for (int i = 0; i < SLAVES; i++)
        if (new_nonces[i]) hold[i] <= slave_nonces[i*32 +: 32];
    end
  end

`ifdef NONCE_OVERRUN_COUNT_EN
  logic overwrite_any;
  assign overwrite_any = |(new_nonces & pending & ~grant_mask);

  always_ff @(posedge hash_clk) begin
    if (rst)                                           overrun_count <= '0;
    else if (overwrite_any && overrun_count != 16'hFFFF) overrun_count <= overrun_count + 16'd1;
  end
`else
  // Overwritten nonces are dropped silently in this build.
`endif

endmodule
